axi_led_bank: RTL

- AXI4-Lite slave driving up to 32 LEDs through a small register map: direct value, write-1-to-set, write-1-to-clear, and per-LED hardware blink with a programmable period.
- Successor to the single-register LED slave. Adds multi-register decode, WSTRB byte enables, per-channel 2-entry request buffering and an autonomous blink engine.
- Sits on the peripheral AXI4-Lite interconnect. o_led drives board pins.

---
 rtl/axi_led_pkg.sv | 48 ++++
 rtl/axi_skid_buffer.sv | 46 ++++
 rtl/axi_led_bank.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_led_pkg.sv
// Shared definitions for the AXI4-Lite LED bank: response codes, register offsets and decode.
// Optional blink registers are decoded only when AXI_LED_BANK_BLINK_EN is defined.
package axi_led_pkg;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] INVALID_RDATA = 32'hDEADDEAD;

  localparam logic [31:0] OFF_LED_OUT      = 32'h00;
  localparam logic [31:0] OFF_LED_SET      = 32'h04;
  localparam logic [31:0] OFF_LED_CLR      = 32'h08;
  localparam logic [31:0] OFF_BLINK_EN     = 32'h0C;
  localparam logic [31:0] OFF_BLINK_PERIOD = 32'h10;

  typedef enum logic [2:0] {
    SelLedOut,
    SelLedSet,
    SelLedClr,
    SelBlinkEn,
    SelBlinkPeriod,
    SelInvalid
  } reg_sel_e;

  // Byte-lane strobes expanded to a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  function automatic reg_sel_e decode_reg(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr & 32'hFFFF_FFFC)
      OFF_LED_OUT:      sel = SelLedOut;
      OFF_LED_SET:      sel = SelLedSet;
      OFF_LED_CLR:      sel = SelLedClr;
`ifdef AXI_LED_BANK_BLINK_EN
      OFF_BLINK_EN:     sel = SelBlinkEn;
      OFF_BLINK_PERIOD: sel = SelBlinkPeriod;
`endif
      default:          sel = SelInvalid;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry valid/ready buffer with fall-through: an empty buffer presents its input directly,
// so a request can be accepted and consumed in the same cycle.
module axi_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;
  logic             push, pop, bypass;

  always_comb begin
    ready_o = !rst_i && (count_q != 2'd2);
    push    = valid_i && ready_o;
    valid_o = (count_q != 2'd0) || push;
    data_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : data_i;
    pop     = valid_o && ready_i;
    bypass  = push && pop && (count_q == 2'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push && !bypass) wr_ptr_q <= !wr_ptr_q;
      if (pop && !bypass)  rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !bypass) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_led_bank.sv
// AXI4-Lite LED bank: direct/set/clear LED registers with optional per-LED blink engine.
// Blink engine and its registers exist only when AXI_LED_BANK_BLINK_EN is defined.
module axi_led_bank
  import axi_led_pkg::*;
#(
  parameter int unsigned AXI_ADDR_BW_p  = 5,
  parameter int unsigned LED_NBR_p      = 32,
  parameter int unsigned BLINK_CNT_BW_p = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  output logic                     o_axi_awready,
  input  logic [31:0]              i_axi_wdata,
  input  logic [3:0]               i_axi_wstrb,
  input  logic                     i_axi_wvalid,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_axi_rready,
  output logic [LED_NBR_p-1:0]     o_led
);

  if (AXI_ADDR_BW_p < 5 || LED_NBR_p < 1 || LED_NBR_p > 32 ||
      BLINK_CNT_BW_p < 1 || BLINK_CNT_BW_p > 32) begin : gen_param_check
    $error("axi_led_bank: parameter out of range");
  end

  localparam logic [31:0] LedMask = 32'((64'd1 << LED_NBR_p) - 64'd1);

  logic                     aw_valid, w_valid, ar_valid;
  logic [AXI_ADDR_BW_p-1:0] aw_addr, ar_addr;
  logic [35:0]              w_payload;
  logic                     wr_exec, rd_exec;

  axi_skid_buffer #(.Width(AXI_ADDR_BW_p)) u_aw_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (i_axi_awvalid),
    .ready_o (o_axi_awready),
    .data_i  (i_axi_awaddr),
    .valid_o (aw_valid),
    .ready_i (wr_exec),
    .data_o  (aw_addr)
  );

  axi_skid_buffer #(.Width(36)) u_w_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (i_axi_wvalid),
    .ready_o (o_axi_wready),
    .data_i  ({i_axi_wdata, i_axi_wstrb}),
    .valid_o (w_valid),
    .ready_i (wr_exec),
    .data_o  (w_payload)
  );

  axi_skid_buffer #(.Width(AXI_ADDR_BW_p)) u_ar_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (i_axi_arvalid),
    .ready_o (o_axi_arready),
    .data_i  (i_axi_araddr),
    .valid_o (ar_valid),
    .ready_i (rd_exec),
    .data_o  (ar_addr)
  );

  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [31:0]          rdata_q;
  logic [31:0]          led_q, led_d;
  logic [LED_NBR_p-1:0] led_out_d, led_out_q;
  reg_sel_e             wr_sel, rd_sel;
  logic [31:0]          wr_mask, wr_bits, rd_data;
  logic [1:0]           wr_resp, rd_resp;

  // A response slot can take a new request when empty or being drained this cycle.
  assign wr_exec = aw_valid && w_valid && (!bvalid_q || i_axi_bready);
  assign rd_exec = ar_valid && (!rvalid_q || i_axi_rready);

`ifdef AXI_LED_BANK_BLINK_EN
  localparam logic [31:0] PerMask = 32'((64'd1 << BLINK_CNT_BW_p) - 64'd1);

  logic [31:0]               blink_en_q, blink_en_d, period_q, period_d;
  logic [BLINK_CNT_BW_p-1:0] presc_q, presc_d;
  logic                      phase_q, phase_d, period_wr;
`endif

  always_comb begin
    wr_sel  = decode_reg(32'(aw_addr));
    wr_mask = strb_mask(w_payload[3:0]);
    wr_bits = w_payload[35:4] & wr_mask;
    wr_resp = (wr_sel == SelInvalid) ? RESP_SLVERR : RESP_OKAY;
    led_d   = led_q;
`ifdef AXI_LED_BANK_BLINK_EN
    blink_en_d = blink_en_q;
    period_d   = period_q;
    period_wr  = 1'b0;
`endif
    if (wr_exec) begin
      case (wr_sel)
        SelLedOut: led_d = ((led_q & ~wr_mask) | wr_bits) & LedMask;
        SelLedSet: led_d = (led_q | wr_bits) & LedMask;
        SelLedClr: led_d = led_q & ~wr_bits;
`ifdef AXI_LED_BANK_BLINK_EN
        SelBlinkEn: blink_en_d = ((blink_en_q & ~wr_mask) | wr_bits) & LedMask;
        SelBlinkPeriod: begin
          period_d  = ((period_q & ~wr_mask) | wr_bits) & PerMask;
          period_wr = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef AXI_LED_BANK_BLINK_EN
  always_comb begin
    presc_d = presc_q + BLINK_CNT_BW_p'(1);
    phase_d = phase_q;
    if (presc_q == period_q[BLINK_CNT_BW_p-1:0]) begin
      presc_d = '0;
      phase_d = !phase_q;
    end
    // A period rewrite restarts the blink half-cycle from a known phase.
    if (period_wr) begin
      presc_d = '0;
      phase_d = 1'b0;
    end
    led_out_d = LED_NBR_p'(led_d ^ (blink_en_d & {32{phase_d}}));
  end
`else
  assign led_out_d = LED_NBR_p'(led_d);
`endif

  always_comb begin
    rd_sel  = decode_reg(32'(ar_addr));
    rd_resp = (rd_sel == SelInvalid) ? RESP_SLVERR : RESP_OKAY;
    rd_data = '0;
    case (rd_sel)
      SelLedOut:      rd_data = led_q;
`ifdef AXI_LED_BANK_BLINK_EN
      SelBlinkEn:     rd_data = blink_en_q;
      SelBlinkPeriod: rd_data = period_q;
`endif
      SelInvalid:     rd_data = INVALID_RDATA;
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      led_out_q <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      led_q     <= led_d;
      led_out_q <= led_out_d;
      if (wr_exec) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (i_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_exec) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp;
        rdata_q  <= rd_data;
      end else if (i_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef AXI_LED_BANK_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_en_q <= '0;
      period_q   <= PerMask;
      presc_q    <= '0;
      phase_q    <= 1'b0;
    end else begin
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
    end
  end
`endif

  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = bresp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rresp  = rresp_q;
  assign o_axi_rdata  = rdata_q;
  assign o_led        = led_out_q;

endmodule
